// File: rtl/mux_sel_sequencer.sv
// Channel scan sequencer for the 4-bit 8:1 mux: select, dwell, sample strobes.
// All outputs registered; settings latched at start and at frame wrap.
module mux_sel_sequencer #(
    parameter int NUM_CH  = 8,
    parameter int SEL_W   = 3,
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic               cont,
    input  logic [NUM_CH-1:0]  ch_en,
    input  logic [DWELL_W-1:0] dwell,
    output logic [SEL_W-1:0]   sel,
    output logic               sel_valid,
    output logic               sample,
    output logic               frame_done,
    output logic               busy
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [SEL_W-1:0]   sel_d;
    logic               sel_valid_d, sample_d, frame_done_d, busy_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic [NUM_CH-1:0]  ch_en_q, ch_en_d;
    logic               cont_q, cont_d;
    logic               stop_pend_q, stop_pend_d;

    logic [SEL_W-1:0]   nxt_sel, lo_new, hi_new;
    logic [DWELL_W-1:0] cnt_inc;
    logic               at_top, nxt_top, last, stop_req, start_ok;

    function automatic logic [SEL_W-1:0] lowest(input logic [NUM_CH-1:0] m);
        lowest = '0;
        for (int k = NUM_CH - 1; k >= 0; k--)
            if (m[k]) lowest = SEL_W'(k);
    endfunction

    function automatic logic [SEL_W-1:0] highest(input logic [NUM_CH-1:0] m);
        highest = '0;
        for (int k = 0; k < NUM_CH; k++)
            if (m[k]) highest = SEL_W'(k);
    endfunction

    function automatic logic has_above(input logic [NUM_CH-1:0] m,
                                       input logic [SEL_W-1:0]  cur);
        has_above = 1'b0;
        for (int k = 0; k < NUM_CH; k++)
            if (m[k] && k > int'(cur)) has_above = 1'b1;
    endfunction

    function automatic logic [SEL_W-1:0] next_above(input logic [NUM_CH-1:0] m,
                                                    input logic [SEL_W-1:0]  cur);
        next_above = cur;
        for (int k = NUM_CH - 1; k >= 0; k--)
            if (m[k] && k > int'(cur)) next_above = SEL_W'(k);
    endfunction

    assign nxt_sel  = next_above(ch_en_q, sel_q_w());
    assign at_top   = !has_above(ch_en_q, sel);
    assign nxt_top  = !has_above(ch_en_q, nxt_sel);
    assign lo_new   = lowest(ch_en);
    assign hi_new   = highest(ch_en);
    assign last     = (cnt_q == dwell_q);
    assign cnt_inc  = cnt_q + DWELL_W'(1);
    assign stop_req = stop_pend_q | stop;
    assign start_ok = start && !stop && (ch_en != '0);

    function automatic logic [SEL_W-1:0] sel_q_w();
        sel_q_w = sel;
    endfunction

    always_comb begin
        state_d      = state_q;
        sel_d        = sel;
        sel_valid_d  = sel_valid;
        busy_d       = busy;
        sample_d     = 1'b0;
        frame_done_d = 1'b0;
        cnt_d        = cnt_q;
        ch_en_d      = ch_en_q;
        dwell_d      = dwell_q;
        cont_d       = cont_q;
        stop_pend_d  = stop_pend_q;
        unique case (state_q)
            IDLE: begin
                stop_pend_d = 1'b0;
                if (start_ok) begin
                    state_d      = RUN;
                    ch_en_d      = ch_en;
                    dwell_d      = dwell;
                    cont_d       = cont;
                    sel_d        = lo_new;
                    sel_valid_d  = 1'b1;
                    busy_d       = 1'b1;
                    cnt_d        = '0;
                    sample_d     = (dwell == '0);
                    frame_done_d = (dwell == '0) && (lo_new == hi_new);
                end
            end
            RUN: begin
                stop_pend_d = stop_req;
                if (!last) begin
                    cnt_d        = cnt_inc;
                    sample_d     = (cnt_inc == dwell_q);
                    frame_done_d = (cnt_inc == dwell_q) && at_top;
                end else if (stop_req ||
                             (at_top && (!cont_q || ch_en == '0))) begin
                    state_d     = IDLE;
                    sel_valid_d = 1'b0;
                    busy_d      = 1'b0;
                    cnt_d       = '0;
                    stop_pend_d = 1'b0;
                end else if (!at_top) begin
                    sel_d        = nxt_sel;
                    cnt_d        = '0;
                    sample_d     = (dwell_q == '0);
                    frame_done_d = (dwell_q == '0) && nxt_top;
                end else begin
                    // frame wrap: new settings take effect here
                    ch_en_d      = ch_en;
                    dwell_d      = dwell;
                    cont_d       = cont;
                    sel_d        = lo_new;
                    cnt_d        = '0;
                    sample_d     = (dwell == '0);
                    frame_done_d = (dwell == '0) && (lo_new == hi_new);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sel         <= '0;
            sel_valid   <= 1'b0;
            sample      <= 1'b0;
            frame_done  <= 1'b0;
            busy        <= 1'b0;
            cnt_q       <= '0;
            dwell_q     <= '0;
            ch_en_q     <= '0;
            cont_q      <= 1'b0;
            stop_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel         <= sel_d;
            sel_valid   <= sel_valid_d;
            sample      <= sample_d;
            frame_done  <= frame_done_d;
            busy        <= busy_d;
            cnt_q       <= cnt_d;
            dwell_q     <= dwell_d;
            ch_en_q     <= ch_en_d;
            cont_q      <= cont_d;
            stop_pend_q <= stop_pend_d;
        end
    end

endmodule

// File: tb/tb_mux_sel_sequencer.sv
// Bench for mux_sel_sequencer: channel-list reference model, directed and
// random scans, async reset, and mux data check at each sample.
module tb_mux_sel_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       cont = 1'b0;
    logic [7:0] ch_en = '0;
    logic [7:0] dwell = '0;
    logic [2:0] sel;
    logic       sel_valid, sample, frame_done, busy;

    logic [3:0] in_arr [8];
    logic [3:0] y;

    int checks = 0;
    int failures = 0;

    // model state: list of channels, position, cycles left in dwell
    bit m_run, m_stop, m_cont;
    int m_pos, m_left, m_dwell;
    int m_list[$];
    int e_sel;
    bit e_sample, e_fd;

    always #5 clk = ~clk;

    assign y = in_arr[sel];

    mux_sel_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .stop       (stop),
        .cont       (cont),
        .ch_en      (ch_en),
        .dwell      (dwell),
        .sel        (sel),
        .sel_valid  (sel_valid),
        .sample     (sample),
        .frame_done (frame_done),
        .busy       (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic build(input logic [7:0] m);
        m_list.delete();
        for (int k = 0; k < 8; k++)
            if (m[k]) m_list.push_back(k);
    endtask

    task automatic relatch();
        build(ch_en);
        m_dwell = int'(dwell);
        m_cont  = cont;
        m_pos   = 0;
        m_left  = m_dwell + 1;
    endtask

    task automatic model_reset();
        m_run = 0; m_stop = 0; m_cont = 0;
        m_pos = 0; m_left = 0; m_dwell = 0;
        e_sel = 0; e_sample = 0; e_fd = 0;
        m_list.delete();
    endtask

    task automatic model_step();
        if (!m_run) begin
            if (start && !stop && ch_en != 0) begin
                relatch();
                m_run  = 1;
                m_stop = 0;
            end
        end else begin
            if (stop) m_stop = 1;
            if (m_left > 1) m_left--;
            else if (m_stop) m_run = 0;
            else if (m_pos < m_list.size() - 1) begin
                m_pos++;
                m_left = m_dwell + 1;
            end else if (m_cont && ch_en != 0) relatch();
            else m_run = 0;
            if (!m_run) m_stop = 0;
        end
        if (m_run) e_sel = m_list[m_pos];
        e_sample = m_run && (m_left == 1);
        e_fd     = e_sample && (m_pos == m_list.size() - 1);
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        chk("sel", 32'(sel), 32'(e_sel));
        chk("sel_valid", 32'(sel_valid), 32'(m_run));
        chk("busy", 32'(busy), 32'(m_run));
        chk("sample", 32'(sample), 32'(e_sample));
        chk("frame_done", 32'(frame_done), 32'(e_fd));
        if (sample) chk("mux_y", 32'(y), 32'(e_sel + 8));
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_sel"}, 32'(sel), 0);
        chk({tag, "_valid"}, 32'(sel_valid), 0);
        chk({tag, "_sample"}, 32'(sample), 0);
        chk({tag, "_fd"}, 32'(frame_done), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
    endtask

    task automatic reset_mid();
        #3;
        rst_n = 1'b0;
        #1;
        check_zero("rst_mid");
        model_reset();
        @(posedge clk);
        @(negedge clk);
        start = 0; stop = 0;
        rst_n = 1'b1;
    endtask

    task automatic drain();
        cont = 0; start = 0; stop = 1;
        cyc();
        stop = 0;
        repeat (10) cyc();
    endtask

    initial begin
        int n;
        bit hit;
        for (int k = 0; k < 8; k++) in_arr[k] = 4'(k + 8);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        cyc();

        // single frame
        ch_en = 8'b1010_0101; dwell = 8'd2; cont = 0; start = 1;
        cyc();
        start = 0;
        for (int t = 1; t <= 13; t++) begin
            chk("sf_sample", 32'(sample), 32'((t % 3 == 0) && t <= 12));
            chk("sf_fd", 32'(frame_done), 32'(t == 12));
            chk("sf_busy", 32'(busy), 32'(t <= 12));
            if (t == 13) chk("sf_sel_end", 32'(sel), 7);
            cyc();
        end

        // continuous with mask change
        ch_en = 8'h03; dwell = 0; cont = 1; start = 1;
        cyc();
        start = 0; ch_en = 8'h80;
        repeat (8) cyc();
        chk("cont_sel7", 32'(sel), 7);
        chk("cont_fd7", 32'(frame_done), 1);
        drain();

        // graceful stop during channel 3
        ch_en = 8'hFF; dwell = 4; cont = 1; start = 1;
        cyc();
        start = 0;
        repeat (16) cyc();
        stop = 1;
        cyc();
        stop = 0;
        repeat (5) cyc();
        chk("stop_sel", 32'(sel), 3);
        chk("stop_valid", 32'(sel_valid), 0);
        repeat (3) cyc();

        // corners: empty mask, start+stop, start during run
        ch_en = 0; start = 1;
        repeat (3) cyc();
        ch_en = 8'h0F; stop = 1;
        repeat (3) cyc();
        stop = 0; dwell = 1; cont = 0;
        cyc();
        repeat (6) cyc();
        start = 0;
        repeat (6) cyc();

        // dwell 255 on channel 4
        ch_en = 8'h10; dwell = 8'd255; cont = 0; start = 1;
        cyc();
        start = 0;
        n = 0; hit = 0;
        for (int i = 0; i < 300 && !hit; i++) begin
            if (sel == 3'd4 && sel_valid) n++;
            if (sample) hit = 1;
            else cyc();
        end
        chk("d255_hit", 32'(hit), 1);
        chk("d255_len", 32'(n), 256);
        drain();

        // randomized episodes
        for (int ep = 0; ep < 20; ep++) begin
            ch_en = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom);
            dwell = 8'($urandom_range(0, 5));
            cont  = 1'($urandom_range(0, 1));
            start = 1;
            stop  = ($urandom_range(0, 9) == 0);
            cyc();
            start = 0; stop = 0;
            for (int i = 0; i < 50; i++) begin
                stop  = ($urandom_range(0, 29) == 0);
                start = ($urandom_range(0, 9) == 0);
                if ($urandom_range(0, 7) == 0) ch_en = 8'($urandom);
                if ($urandom_range(0, 7) == 0) dwell = 8'($urandom_range(0, 5));
                if ($urandom_range(0, 7) == 0) cont = 1'($urandom_range(0, 1));
                if (ep == 10 && i == 20) reset_mid();
                cyc();
            end
            drain();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
